// File: rtl/debug_cmd_pkg.sv
// debug_cmd_pkg: opcodes, response codes and FSM states for the debug command engine
package debug_cmd_pkg;
  localparam logic [7:0] OP_HALT = 8'h01;
  localparam logic [7:0] OP_RUN = 8'h02;
  localparam logic [7:0] OP_WRITE = 8'h03;
  localparam logic [7:0] OP_READ = 8'h04;
  localparam logic [7:0] OP_STATUS = 8'h05;
  localparam logic [7:0] RSP_HALT = 8'h81;
  localparam logic [7:0] RSP_RUN = 8'h82;
  localparam logic [7:0] RSP_WRITE = 8'h83;
  localparam logic [7:0] RSP_READ = 8'h84;
  localparam logic [7:0] RSP_STATUS = 8'h85;
  localparam logic [7:0] RSP_BAD_OP = 8'hE0;
  localparam logic [7:0] RSP_NOT_HALTED = 8'hE1;
  localparam logic [7:0] RSP_TIMEOUT = 8'hE2;
  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, CHECK, ACCESS, SEND} state_t;
endpackage

// File: rtl/debug_command_engine_if.sv
// debug_command_engine_if: host byte link plus debug-unit bus seen by the engine
interface debug_command_engine_if;
  logic [7:0] rxData;
  logic rxValid;
  logic rxReady;
  logic [7:0] txData;
  logic txValid;
  logic txReady;
  logic dbgStall;
  logic dbgStb;
  logic dbgWe;
  logic [15:0] dbgAdr;
  logic [31:0] dbgDatOut;
  logic [31:0] dbgDatIn;
  logic dbgAck;
  logic dbgBreakpoint;
  logic halted;
  modport slave(
    input rxData, rxValid, txReady, dbgDatIn, dbgAck, dbgBreakpoint,
    output rxReady, txData, txValid, dbgStall, dbgStb, dbgWe, dbgAdr, dbgDatOut, halted
  );
  modport master(
    output rxData, rxValid, txReady, dbgDatIn, dbgAck, dbgBreakpoint,
    input rxReady, txData, txValid, dbgStall, dbgStb, dbgWe, dbgAdr, dbgDatOut, halted
  );
endinterface

// File: rtl/debug_byte_shifter.sv
// debug_byte_shifter: 32-bit byte-wide load/shift register with a down-counting byte counter
module debug_byte_shifter (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        shift,
  input  logic [31:0] load_data,
  input  logic [2:0]  load_cnt,
  input  logic [7:0]  din,
  output logic [31:0] data,
  output logic [2:0]  cnt
);
  // load wins over shift; each shift moves one byte towards the MSB end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      data <= '0;
      cnt <= '0;
    end else if (load) begin
      data <= load_data;
      cnt <= load_cnt;
    end else if (shift) begin
      data <= {data[23:0], din};
      cnt <= cnt - 3'd1;
    end
endmodule

// File: rtl/debug_command_engine.sv
// debug_command_engine: byte-serial host command decoder driving the debug unit bus
module debug_command_engine
  import debug_cmd_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255,
  parameter bit STALL_ON_BREAKPOINT = 1'b1
) (
  input logic clock,
  input logic reset,
  debug_command_engine_if.slave bus
);
  state_t state, state_n;
  logic live, hdr, hdr_n, is_write, is_write_n, stall, bp_flag, bp_prev, halt_cmd, run_cmd;
  logic [7:0] code, code_n, sh_din;
  logic [15:0] adr, adr_n, timer, timer_n;
  logic [31:0] dat, dat_n, sh_ldata, sh_data;
  logic [2:0] sh_lcnt, sh_cnt;
  logic sh_load, sh_shift;
  logic rx_fire, tx_fire, bp_edge;

  debug_byte_shifter shifter (
    .clock(clock), .reset(reset), .load(sh_load), .shift(sh_shift),
    .load_data(sh_ldata), .load_cnt(sh_lcnt), .din(sh_din), .data(sh_data), .cnt(sh_cnt)
  );

  assign rx_fire = bus.rxValid & bus.rxReady;
  assign tx_fire = bus.txValid & bus.txReady;
  assign bp_edge = bus.dbgBreakpoint & ~bp_prev;
  assign bus.rxReady = live & (state == IDLE || state == GET_ADDR || state == GET_DATA);
  assign bus.txValid = state == SEND;
  assign bus.txData = hdr ? code : sh_data[31:24];
  assign bus.dbgStb = state == ACCESS;
  assign bus.dbgWe = state == ACCESS && is_write;
  assign bus.dbgAdr = adr;
  assign bus.dbgDatOut = dat;
  assign bus.dbgStall = stall;
  assign bus.halted = stall;

  // state register
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;

  // next-state, operand assembly, bus access and response sequencing
  always_comb begin
    state_n = state;
    code_n = code;
    hdr_n = hdr;
    is_write_n = is_write;
    adr_n = adr;
    dat_n = dat;
    timer_n = timer;
    halt_cmd = 1'b0;
    run_cmd = 1'b0;
    sh_load = 1'b0;
    sh_shift = 1'b0;
    sh_ldata = '0;
    sh_lcnt = '0;
    sh_din = bus.rxData;
    case (state)
      IDLE: if (rx_fire) begin
        state_n = SEND;
        sh_load = 1'b1;
        case (bus.rxData)
          OP_HALT: begin halt_cmd = 1'b1; code_n = RSP_HALT; end
          OP_RUN: begin run_cmd = 1'b1; code_n = RSP_RUN; end
          OP_WRITE, OP_READ: begin
            state_n = GET_ADDR;
            is_write_n = bus.rxData == OP_WRITE;
            sh_lcnt = 3'd2;
          end
          OP_STATUS: begin
            code_n = RSP_STATUS;
            sh_ldata = {6'b0, bp_flag, stall, 24'b0};
            sh_lcnt = 3'd1;
          end
          default: code_n = RSP_BAD_OP;
        endcase
      end
      GET_ADDR: if (rx_fire) begin
        sh_shift = 1'b1;
        if (sh_cnt == 3'd1) begin
          adr_n = {sh_data[7:0], bus.rxData};
          state_n = is_write ? GET_DATA : CHECK;
          sh_load = is_write;
          sh_lcnt = 3'd4;
        end
      end
      GET_DATA: if (rx_fire) begin
        sh_shift = 1'b1;
        if (sh_cnt == 3'd1) begin
          dat_n = {sh_data[23:0], bus.rxData};
          state_n = CHECK;
        end
      end
      CHECK: begin
        timer_n = '0;
        state_n = stall ? ACCESS : SEND;
        code_n = stall ? code : RSP_NOT_HALTED;
        sh_load = ~stall;
      end
      ACCESS: begin
        timer_n = timer + 16'd1;
        if (bus.dbgAck) begin
          state_n = SEND;
          code_n = is_write ? RSP_WRITE : RSP_READ;
          sh_load = 1'b1;
          sh_ldata = bus.dbgDatIn;
          sh_lcnt = is_write ? 3'd0 : 3'd4;
        end else if (timer == 16'(ACK_TIMEOUT - 1)) begin
          state_n = SEND;
          code_n = RSP_TIMEOUT;
          sh_load = 1'b1;
        end
      end
      SEND: if (tx_fire) begin
        hdr_n = 1'b0;
        sh_shift = ~hdr;
        sh_din = 8'h00;
        state_n = (hdr ? sh_cnt == 3'd0 : sh_cnt == 3'd1) ? IDLE : SEND;
      end
      default: state_n = IDLE;
    endcase
    if (state_n == SEND && state != SEND) hdr_n = 1'b1;
  end

  // datapath registers, stall/breakpoint tracking; a breakpoint edge beats RUN
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      live <= 1'b0;
      hdr <= 1'b0;
      is_write <= 1'b0;
      code <= '0;
      adr <= '0;
      dat <= '0;
      timer <= '0;
      stall <= 1'b0;
      bp_flag <= 1'b0;
      bp_prev <= 1'b0;
    end else begin
      live <= 1'b1;
      hdr <= hdr_n;
      is_write <= is_write_n;
      code <= code_n;
      adr <= adr_n;
      dat <= dat_n;
      timer <= timer_n;
      bp_prev <= bus.dbgBreakpoint;
      bp_flag <= bp_edge | (bp_flag & ~run_cmd);
      stall <= (bp_edge & STALL_ON_BREAKPOINT) | halt_cmd | (stall & ~run_cmd);
    end
endmodule

// File: tb/tb_debug_command_engine.sv
// tb_debug_command_engine: directed stimulus with a response scoreboard and bus monitor
module tb_debug_command_engine;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic ack_en = 1'b1;
  int stb_cnt = 0;
  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int stb_len = 0;
  int last_len = 0;
  int pulses = 0;
  int base;
  logic [15:0] exp_adr = '0;
  logic [31:0] exp_dat = '0;
  logic exp_we = 1'b0;
  logic [7:0] exp_q[$];

  debug_command_engine_if bus ();
  debug_command_engine #(.ACK_TIMEOUT(8)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  // debug-unit model: ack in the third strobe cycle when enabled
  always @(posedge clock) stb_cnt <= bus.dbgStb ? stb_cnt + 1 : 0;
  assign bus.dbgAck = ack_en & bus.dbgStb & (stb_cnt == 2);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, {bus.rxReady, bus.txValid, bus.txData, bus.dbgStall, bus.dbgStb, bus.dbgWe,
               bus.dbgAdr, bus.dbgDatOut, bus.halted}, 64'd0);
  endtask

  // response scoreboard and strobe monitor, sampled mid-cycle
  always @(negedge clock) begin
    if (reset && bus.txValid && bus.txReady) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got %h expected no byte", bus.txData);
      end else begin
        chk("tx_byte", bus.txData, exp_q.pop_front());
        rx_cnt++;
      end
    end else if (reset && bus.txValid && exp_q.size() != 0) chk("tx_hold", bus.txData, exp_q[0]);
    if (bus.dbgStb) begin
      stb_len++;
      chk("stb_adr", bus.dbgAdr, exp_adr);
      chk("stb_we", bus.dbgWe, exp_we);
      if (exp_we) chk("stb_dat", bus.dbgDatOut, exp_dat);
    end else if (stb_len != 0) begin
      last_len = stb_len;
      pulses++;
      stb_len = 0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    bus.rxData = b;
    bus.rxValid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clock);
      done = bus.rxReady;
      @(posedge clock);
      #1;
    end
    bus.rxValid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL rx_accept: byte %h got not accepted expected accepted", b);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clock);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d bytes missing expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    bus.rxData = '0;
    bus.rxValid = 1'b0;
    bus.txReady = 1'b1;
    bus.dbgDatIn = '0;
    bus.dbgBreakpoint = 1'b0;
    repeat (3) @(posedge clock);
    #1 chk_zero("reset_outputs");
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1;
    // READ while running: rejected without touching the bus
    exp_q.push_back(8'hE1);
    send_byte(8'h04); send_byte(8'h30); send_byte(8'h14);
    drain();
    chk("no_stb_when_running", pulses, 0);
    // HALT then WRITE
    exp_q.push_back(8'h81);
    send_byte(8'h01);
    drain();
    chk("halted_after_halt", {bus.halted, bus.dbgStall}, 2'b11);
    exp_adr = 16'h3014; exp_dat = 32'h00002000; exp_we = 1'b1;
    exp_q.push_back(8'h83);
    send_byte(8'h03); send_byte(8'h30); send_byte(8'h14);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h20); send_byte(8'h00);
    drain();
    chk("write_pulses", pulses, 1);
    chk("write_stb_len", last_len, 3);
    // READ with back-pressure mid-stream
    exp_we = 1'b0;
    bus.dbgDatIn = 32'h00002000;
    base = rx_cnt;
    exp_q.push_back(8'h84); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'h20); exp_q.push_back(8'h00);
    send_byte(8'h04); send_byte(8'h30); send_byte(8'h14);
    for (int i = 0; i < 100 && rx_cnt < base + 2; i++) begin
      @(posedge clock);
      #1;
    end
    bus.txReady = 1'b0;
    repeat (5) @(posedge clock);
    #1 bus.txReady = 1'b1;
    drain();
    chk("read_bytes", rx_cnt - base, 5);
    chk("read_stb_len", last_len, 3);
    // no ack: timeout after exactly 8 strobe cycles
    ack_en = 1'b0;
    exp_adr = 16'h0010;
    exp_q.push_back(8'hE2);
    send_byte(8'h04); send_byte(8'h00); send_byte(8'h10);
    drain();
    chk("timeout_stb_len", last_len, 8);
    ack_en = 1'b1;
    exp_q.push_back(8'h85); exp_q.push_back(8'h01);
    send_byte(8'h05);
    drain();
    // breakpoint while running
    exp_q.push_back(8'h82);
    send_byte(8'h02);
    drain();
    chk("running_after_run", bus.halted, 1'b0);
    bus.dbgBreakpoint = 1'b1;
    repeat (2) @(posedge clock);
    #1 bus.dbgBreakpoint = 1'b0;
    chk("bp_stall", bus.dbgStall, 1'b1);
    exp_q.push_back(8'h85); exp_q.push_back(8'h03);
    send_byte(8'h05);
    drain();
    exp_q.push_back(8'h82);
    send_byte(8'h02);
    drain();
    exp_q.push_back(8'h85); exp_q.push_back(8'h00);
    send_byte(8'h05);
    drain();
    // unknown opcode
    exp_q.push_back(8'hE0);
    send_byte(8'h7F);
    drain();
    // reset in the middle of WRITE operands
    exp_q.push_back(8'h81);
    send_byte(8'h01);
    drain();
    send_byte(8'h03); send_byte(8'h30); send_byte(8'h14); send_byte(8'h00);
    reset = 1'b0;
    #1 chk_zero("reset_mid_write");
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1;
    exp_q.push_back(8'h81);
    send_byte(8'h01);
    drain();
    // reset during an access drops strobe without waiting for a clock
    ack_en = 1'b0;
    exp_adr = 16'h0020;
    send_byte(8'h04); send_byte(8'h00); send_byte(8'h20);
    for (int i = 0; i < 50 && !bus.dbgStb; i++) @(negedge clock);
    chk("stb_before_reset", bus.dbgStb, 1'b1);
    #2 reset = 1'b0;
    #1 chk_zero("reset_mid_access");
    @(negedge clock) reset = 1'b1;
    ack_en = 1'b1;
    @(posedge clock);
    #1;
    exp_q.push_back(8'h85); exp_q.push_back(8'h00);
    send_byte(8'h05);
    drain();
    repeat (5) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/debug_command_engine.md
Name: debug_command_engine

Overview:
- Upstream host-side driver of the or1300 debug unit's external debug interface.
- Receives a byte-serial command stream from the host link (UART/JTAG byte bridge) and drives stall, strobe, write-enable, address and data into the debug unit.
- Waits for the debug unit's acknowledge, then returns a status/data byte stream.
- Latches breakpoint events from the debug unit and optionally auto-stalls the core on them.

Parameters:
- ACK_TIMEOUT, 255: cycles to wait for dbgAck after strobe assertion before aborting; range 4..65535.
- STALL_ON_BREAKPOINT, 1: when 1, a dbgBreakpoint rising edge sets the stall register.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rxData  in  8  command byte from host link
- rxValid  in  1  rxData valid
- rxReady  out  1  engine accepts rxData this cycle
- txData  out  8  response byte to host link
- txValid  out  1  txData valid
- txReady  in  1  host link accepts txData this cycle
- dbgStall  out  1  to debug unit dbg_stall_i
- dbgStb  out  1  to dbg_stb_i
- dbgWe  out  1  to dbg_we_i
- dbgAdr  out  16  to dbg_adr_i (SPR index)
- dbgDatOut  out  32  to dbg_dat_i
- dbgDatIn  in  32  from dbg_dat_o
- dbgAck  in  1  from dbg_ack_o
- dbgBreakpoint  in  1  from dbg_bp_o
- halted  out  1  mirrors dbgStall, for status LED/top level

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs 0: rxReady, txValid, txData, dbgStall, dbgStb, dbgWe, dbgAdr, dbgDatOut, halted. bpFlag cleared, all counters cleared.
- Byte transfers:
  - A byte is accepted only when rxValid&rxReady in the same cycle.
  - A byte is sent only when txValid&txReady; txData is held stable while txValid=1 and txReady=0.
  - rxReady=1 only in IDLE, GET_ADDR and GET_DATA.
- Opcodes, taken in IDLE:
  - 0x01 HALT: set dbgStall. Response 0x81.
  - 0x02 RUN: clear dbgStall and bpFlag. Response 0x82.
  - 0x03 WRITE: 2 address bytes then 4 data bytes, MSB first. Response 0x83.
  - 0x04 READ: 2 address bytes. Response 0x84, then 4 data bytes MSB first.
  - 0x05 STATUS: response 0x85, then {6'b0, bpFlag, dbgStall}.
  - Any other opcode: response 0xE0; no operand bytes are consumed.
- States: IDLE -> GET_ADDR (byte count 2) -> GET_DATA (WRITE only, byte count 4) -> CHECK -> ACCESS -> SEND -> IDLE.
- CHECK:
  - If dbgStall=0, no access is performed and the response is 0xE1. The debug unit ignores accesses while not stalled.
  - Operands are always fully consumed before the 0xE1 response.
- ACCESS:
  - dbgStb=1, with dbgWe=1 for WRITE and 0 for READ.
  - dbgAdr and dbgDatOut are stable from the first strobe cycle until strobe drops.
  - Strobe is held until the first cycle dbgAck=1. In that cycle, a READ captures dbgDatIn into the response shift register.
  - dbgStb drops the next cycle.
  - The debug unit acks no earlier than the 2nd cycle after strobe rise, so minimum ACCESS length is 3 cycles.
  - Strobe must stay low for at least 2 cycles between accesses; the SEND phase guarantees this.
- Timeout:
  - The 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle.
  - At count == ACK_TIMEOUT with no ack: drop dbgStb and respond 0xE2 with no data bytes.
  - An ack arriving in the same cycle as the timeout wins; the access completes normally.
- SEND: shifts out 1, 2 or 5 bytes; the byte counter is 3 bits. Returns to IDLE after the last byte is accepted.
- Breakpoint handling:
  - A rising edge on dbgBreakpoint (registered previous value) sets bpFlag in any state.
  - It also sets dbgStall if STALL_ON_BREAKPOINT=1.
  - RUN in the same cycle as a breakpoint edge: the breakpoint wins, so stall and bpFlag stay set.
- halted = dbgStall combinationally; no extra latency.
- Reset mid-ACCESS: dbgStb drops immediately (asynchronous). The partially received command is discarded.

Decomposition:
- Shared package debug_cmd_pkg:
  - opcode constants (0x01..0x05);
  - response codes (0x81..0x85, 0xE0, 0xE1, 0xE2);
  - state encoding localparams.
- One natural sub-module, debug_byte_shifter: a 32-bit load/shift register with a 3-bit byte counter. It is used for operand assembly (shift in) and response serialisation (shift out).

Test Plan:
- READ while not halted: 0x04,0x30,0x14 -> no dbgStb pulse; response 0xE1.
- HALT, then WRITE 0x03,0x30,0x14,0x00,0x00,0x20,0x00 -> response 0x81. Then dbgStb=1, dbgWe=1, dbgAdr=0x3014, dbgDatOut=0x00002000 until ack (model acks on strobe cycle 2); response 0x83.
- READ 0x04,0x30,0x14 with model returning 0x00002000 at ack -> bytes 0x84,0x00,0x00,0x20,0x00. Hold txReady=0 for 5 cycles mid-stream -> txData held stable, no byte lost.
- Model never acks, ACK_TIMEOUT=8 -> dbgStb high exactly 8 cycles, then low; response 0xE2; next STATUS command works.
- Pulse dbgBreakpoint while running -> dbgStall=1. STATUS returns 0x85,0x03; RUN returns 0x82; STATUS then returns 0x85,0x00.
- Unknown opcode 0x7F -> 0xE0. Assert reset mid-WRITE operand stream -> all outputs 0. The next HALT yields 0x81.
